// File: rtl/uart_echo_param.sv
// uart_echo_param: 16x-oversampled UART receiver, FIFO and transmitter that echoes every good frame
module uart_echo_param #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK100MHZ,
  input  logic                          reset_n,
  input  logic                          isRX,
  input  logic                          isTX,
  input  logic                          RXD,
  input  logic                          err_clr,
  output logic                          TXD,
  output logic [$clog2(FIFO_DEPTH):0]   depth,
  output logic                          empty,
  output logic                          full,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overrun
);
  localparam int DIV = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int DW  = PW + 1;
  localparam logic [CW-1:0] DLAST = CW'(DIV - 1);
  localparam logic [DW-1:0] DMAX  = DW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  function automatic logic par_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  logic [CW-1:0] div_cnt;
  logic          tick;
  logic          rx_s1, rx_s2, rx_prev;

  state_t                 rx_state, rx_state_n;
  logic [3:0]             rx_tcnt, rx_tcnt_n, rx_bcnt, rx_bcnt_n;
  logic [DATA_BITS-1:0]   rx_sh, rx_sh_n;
  logic                   rx_pbad, rx_pbad_n, rx_sbad, rx_sbad_n;
  logic                   frame_bad, set_pe, set_fe, set_ov;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]          wp, rp;
  logic                   fifo_wr, fifo_rd;

  state_t                 tx_state, tx_state_n;
  logic [CW-1:0]          tx_pc, tx_pc_n;
  logic [3:0]             tx_tcnt, tx_tcnt_n, tx_bcnt, tx_bcnt_n;
  logic [DATA_BITS-1:0]   tx_sh, tx_sh_n;
  logic                   tx_par, tx_par_n, txd_n, btick;

  assign tick  = div_cnt == DLAST;
  assign empty = depth == '0;
  assign full  = depth == DMAX;
  assign btick = (tx_pc == DLAST) && (tx_tcnt == 4'd15);

  // free-running 16x oversampling tick shared by the receiver
  always_ff @(posedge CLK100MHZ or negedge reset_n)
    if (!reset_n) div_cnt <= '0;
    else          div_cnt <= tick ? '0 : div_cnt + CW'(1);

  // two-flop synchroniser plus one delay flop for falling-edge detection
  always_ff @(posedge CLK100MHZ or negedge reset_n)
    if (!reset_n) {rx_prev, rx_s2, rx_s1} <= 3'b111;
    else          {rx_prev, rx_s2, rx_s1} <= {rx_s2, rx_s1, RXD};

  // receiver state and datapath registers
  always_ff @(posedge CLK100MHZ or negedge reset_n)
    if (!reset_n) begin
      rx_state <= IDLE;
      rx_tcnt  <= '0;
      rx_bcnt  <= '0;
      rx_sh    <= '0;
      rx_pbad  <= 1'b0;
      rx_sbad  <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_tcnt  <= rx_tcnt_n;
      rx_bcnt  <= rx_bcnt_n;
      rx_sh    <= rx_sh_n;
      rx_pbad  <= rx_pbad_n;
      rx_sbad  <= rx_sbad_n;
    end

  // receiver next state: every sample lands on tick 8 of its bit, the end-of-frame decision picks one outcome
  always_comb begin
    rx_state_n = rx_state;
    rx_tcnt_n  = rx_tcnt;
    rx_bcnt_n  = rx_bcnt;
    rx_sh_n    = rx_sh;
    rx_pbad_n  = rx_pbad;
    rx_sbad_n  = rx_sbad;
    fifo_wr    = 1'b0;
    set_pe     = 1'b0;
    set_fe     = 1'b0;
    set_ov     = 1'b0;
    frame_bad  = rx_sbad | ~rx_s2;
    if (rx_state == IDLE) begin
      if (isRX && rx_prev && !rx_s2) begin
        rx_state_n = START;
        rx_tcnt_n  = '0;
        rx_bcnt_n  = '0;
        rx_pbad_n  = 1'b0;
        rx_sbad_n  = 1'b0;
      end
    end else if (!isRX) begin
      rx_state_n = IDLE;
    end else if (tick) begin
      rx_tcnt_n = rx_tcnt + 4'd1;
      if (rx_tcnt == 4'd7) begin
        case (rx_state)
          START: rx_state_n = rx_s2 ? IDLE : DATA;
          DATA: begin
            rx_sh_n   = {rx_s2, rx_sh[DATA_BITS-1:1]};
            rx_bcnt_n = rx_bcnt + 4'd1;
            if (rx_bcnt == 4'(DATA_BITS - 1)) begin
              rx_bcnt_n = '0;
              if (PARITY != 0) rx_state_n = PAR;
              else             rx_state_n = STOP;
            end
          end
          PAR: begin
            rx_pbad_n  = rx_s2 != par_of(rx_sh);
            rx_state_n = STOP;
          end
          STOP: begin
            rx_sbad_n = frame_bad;
            rx_bcnt_n = rx_bcnt + 4'd1;
            if (rx_bcnt == 4'(STOP_BITS - 1)) begin
              rx_state_n = IDLE;
              set_fe     = frame_bad;
              set_pe     = !frame_bad && rx_pbad;
              set_ov     = !frame_bad && !rx_pbad && full && !fifo_rd;
              fifo_wr    = !frame_bad && !rx_pbad && (!full || fifo_rd);
            end
          end
          default: rx_state_n = IDLE;
        endcase
      end
    end
  end

  // FIFO storage; contents need no reset because depth guards every read
  always_ff @(posedge CLK100MHZ)
    if (fifo_wr) mem[wp] <= rx_sh;

  // FIFO pointers and occupancy
  always_ff @(posedge CLK100MHZ or negedge reset_n)
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      depth <= '0;
    end else begin
      wp    <= wp + PW'(fifo_wr);
      rp    <= rp + PW'(fifo_rd);
      depth <= (fifo_wr == fifo_rd) ? depth : fifo_wr ? depth + DW'(1) : depth - DW'(1);
    end

  // transmitter state, bit timer and registered line output
  always_ff @(posedge CLK100MHZ or negedge reset_n)
    if (!reset_n) begin
      tx_state <= IDLE;
      tx_pc    <= '0;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      TXD      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_pc    <= tx_pc_n;
      tx_tcnt  <= tx_tcnt_n;
      tx_bcnt  <= tx_bcnt_n;
      tx_sh    <= tx_sh_n;
      tx_par   <= tx_par_n;
      TXD      <= txd_n;
    end

  // transmitter next state: the bit timer restarts at each pop so bit edges align to the start bit
  always_comb begin
    tx_state_n = tx_state;
    tx_pc_n    = (tx_pc == DLAST) ? '0 : tx_pc + CW'(1);
    tx_tcnt_n  = tx_tcnt + {3'b000, tx_pc == DLAST};
    tx_bcnt_n  = tx_bcnt;
    tx_sh_n    = tx_sh;
    tx_par_n   = tx_par;
    fifo_rd    = 1'b0;
    case (tx_state)
      IDLE: begin
        tx_pc_n   = '0;
        tx_tcnt_n = '0;
        if (isTX && !empty) begin
          fifo_rd    = 1'b1;
          tx_state_n = START;
          tx_sh_n    = mem[rp];
          tx_par_n   = par_of(mem[rp]);
          tx_bcnt_n  = '0;
        end
      end
      START: if (btick) tx_state_n = DATA;
      DATA: if (btick) begin
        tx_sh_n   = tx_sh >> 1;
        tx_bcnt_n = tx_bcnt + 4'd1;
        if (tx_bcnt == 4'(DATA_BITS - 1)) begin
          tx_bcnt_n = '0;
          if (PARITY != 0) tx_state_n = PAR;
          else             tx_state_n = STOP;
        end
      end
      PAR: if (btick) tx_state_n = STOP;
      STOP: if (btick) begin
        tx_bcnt_n = tx_bcnt + 4'd1;
        if (tx_bcnt == 4'(STOP_BITS - 1)) tx_state_n = IDLE;
      end
      default: tx_state_n = IDLE;
    endcase
    txd_n = (tx_state_n == START) ? 1'b0 :
            (tx_state_n == DATA)  ? tx_sh_n[0] :
            (tx_state_n == PAR)   ? tx_par : 1'b1;
  end

  // sticky error flags; a new error wins over a simultaneous clear
  always_ff @(posedge CLK100MHZ or negedge reset_n)
    if (!reset_n) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      parity_err <= set_pe | (parity_err & ~err_clr);
      frame_err  <= set_fe | (frame_err & ~err_clr);
      overrun    <= set_ov | (overrun & ~err_clr);
    end
endmodule
